fixedpoint_accumulator: RTL

- Consumes the 32-bit signed products from fixedpoint_multiplier and sums a burst of them into a wide internal accumulator.
- Burst length is programmed at start. One result is returned per burst, saturated to the output width, over a valid/ready handshake.
- Forms the "Acc" half of the MulAdd_Acc datapath. It sits directly downstream of the multiplier.

---
 rtl/fixedpoint_pkg.sv | 33 +++
 rtl/fixedpoint_sat_add.sv | 26 ++
 rtl/fixedpoint_accumulator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fixedpoint_pkg.sv
// Shared types, default widths and saturation helper for the burst accumulator.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package fixedpoint_pkg;

    localparam int WIDTH_INPUT_DEF  = 32;
    localparam int WIDTH_ACC_DEF    = 40;
    localparam int WIDTH_OUTPUT_DEF = 32;
    localparam int WIDTH_LEN_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } acc_state_t;

    // Clamp a signed value into the signed range of 'width' bits (width <= 64).
    // Callers detect clamping by comparing the result against the input.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/fixedpoint_sat_add.sv
// Signed saturating adder: W-bit sum clamped to the W-bit range, with overflow flag.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module fixedpoint_sat_add
    import fixedpoint_pkg::*;
#(
    parameter int W = WIDTH_ACC_DEF
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [W:0]  wide;
    logic signed [63:0] wide64;
    logic signed [63:0] clamped;

    // One extra bit holds the exact sum of two W-bit operands.
    assign wide    = {a[W-1], a} + {b[W-1], b};
    assign wide64  = 64'(wide);
    assign clamped = sat_narrow(wide64, W);
    assign sum     = clamped[W-1:0];
    assign ovf     = (clamped != wide64);

endmodule

// File: rtl/fixedpoint_accumulator.sv
// Sums a programmed-length burst of signed products; one saturated result per burst.
// Latency: result valid the cycle after the edge following final-beat acceptance.
// Backpressure: ready_o only while beats remain; result held until ready_i.
module fixedpoint_accumulator
    import fixedpoint_pkg::*;
#(
    parameter int WIDTH_INPUT  = WIDTH_INPUT_DEF,
    parameter int WIDTH_ACC    = WIDTH_ACC_DEF,
    parameter int WIDTH_OUTPUT = WIDTH_OUTPUT_DEF,
    parameter int WIDTH_LEN    = WIDTH_LEN_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [WIDTH_LEN-1:0]    len_i,
    input  logic [WIDTH_INPUT-1:0]  data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [WIDTH_OUTPUT-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    sat_o,
    output logic                    busy_o
);

    acc_state_t                  state;
    acc_state_t                  state_next;
    logic signed [WIDTH_ACC-1:0] acc;
    logic signed [WIDTH_ACC-1:0] beat_ext;
    logic signed [WIDTH_ACC-1:0] add_sum;
    logic                        add_ovf;
    logic [WIDTH_LEN-1:0]        cnt;
    logic                        sat_flag;
    logic                        accept;
    logic signed [63:0]          acc_wide;
    logic signed [63:0]          acc_narrow;
    logic                        out_ovf;

    assign beat_ext   = {{(WIDTH_ACC-WIDTH_INPUT){data_i[WIDTH_INPUT-1]}}, data_i};
    assign accept     = valid_i && ready_o;
    assign acc_wide   = 64'(acc);
    assign acc_narrow = sat_narrow(acc_wide, WIDTH_OUTPUT);
    assign out_ovf    = (acc_narrow != acc_wide);

    fixedpoint_sat_add #(
        .W (WIDTH_ACC)
    ) u_sat_add (
        .a   (acc),
        .b   (beat_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: ACCUM drains once the counter hits zero, OUTPUT waits for ready_i.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (len_i == '0) ? OUTPUT : ACCUM;
                end
            end
            ACCUM: begin
                if (cnt == '0) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state; ready drops as soon as the count is spent.
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        busy_o  = (state != IDLE);
        case (state)
            ACCUM:   ready_o = (cnt != '0);
            OUTPUT:  valid_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath: burst setup, beat accumulation, and result narrowing on entry to OUTPUT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
            data_o   <= '0;
            sat_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc      <= '0;
                        sat_flag <= 1'b0;
                        cnt      <= len_i;
                        if (len_i == '0) begin
                            data_o <= '0;
                            sat_o  <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc      <= add_sum;
                        sat_flag <= sat_flag | add_ovf;
                        cnt      <= cnt - WIDTH_LEN'(1);
                    end
                    if (cnt == '0) begin
                        data_o <= acc_narrow[WIDTH_OUTPUT-1:0];
                        sat_o  <= sat_flag | out_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
